rv32_lsu: RTL and testbench
===========================

# rv32_lsu

Load/store unit for the RV32 memory stage. It turns a memory-stage access (load or store, byte/half/word) into a single valid/ready transaction on the data bus and aligns byte lanes. It raises a stall request to the hazard unit until the access has completed, and sign- or zero-extends load data. It is the stall source for the memory stage: the hazard unit consumes `mem_stall_req_out` and returns stall/flush.

## Interface
Parameters: none. Data and address widths are fixed at 32 bits.

Clock and reset:
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.

Memory-stage inputs:
- `read_en_in` in 1: load in the stage.
- `write_en_in` in 1: store in the stage.
- `width_in` in 2: `rv32_mem_width_t` (BYTE, HALF, WORD).
- `zero_extend_in` in 1: load is zero-extended (LBU/LHU).
- `address_in` in 32: effective address.
- `write_value_in` in 32: store data, value in the low bits.
- `stall_in` in 1: memory stage is held by the hazard unit.
- `flush_in` in 1: instruction in the stage is squashed.

Outputs to the pipeline and hazard unit:
- `read_value_out` out 32: extended load result. Valid in DONE.
- `mem_stall_req_out` out 1: hold the pipeline; the access is not complete.
- `misaligned_out` out 1: the access is misaligned. The bus is not touched.

Data bus:
- `bus_address_out` out 32: word address, low 2 bits = 0.
- `bus_valid_out` out 1: request valid.
- `bus_write_out` out 1: 1 = store, 0 = load.
- `bus_write_mask_out` out 4: byte enables.
- `bus_write_value_out` out 32: lane-replicated store data.
- `bus_ready_in` in 1: request accepted and complete this cycle.
- `bus_read_value_in` in 32: load word. Valid with `bus_ready_in`.

## Operation
States are IDLE, REQ and DONE. There is also a `drop` flag.

- **Pending access:** `access = (read_en_in | write_en_in) & ~flush_in & ~misaligned_out`.
- **Misalignment:** HALF with `address_in[0]`, or WORD with `address_in[1:0] != 0`.
  - `misaligned_out` is combinational.
  - A misaligned access issues no request and raises no stall.
- **IDLE:** if `access`, register address/mask/data/write/width/extend/`addr[1:0]` → REQ.
- **REQ:**
  - `bus_valid_out = 1`, driven from the registered values.
  - Request fields must stay stable until `bus_ready_in`.
  - On `bus_ready_in`, capture `bus_read_value_in`, then:
    - `drop` = 1: go to IDLE and clear `drop`.
    - Otherwise: go to DONE.
- **DONE:**
  - `read_value_out` is valid.
  - If `stall_in` = 0 or `flush_in` = 1 → IDLE.
  - A new access is not accepted in the DONE cycle.
- **Flush in REQ:** the bus transaction is never aborted.
  - `flush_in` sets `drop`. The result is discarded.
- **Stall request:** `mem_stall_req_out = access & (state==IDLE | state==REQ)`.
  - While `drop` is set, this covers a new instruction waiting on the busy bus.
  - In DONE it is 0.
- **Write mask:**
  - BYTE: `1 << addr[1:0]`.
  - HALF: `4'b0011 << addr[1:0]`.
  - WORD: `4'b1111`.
  - Loads: `4'b0000`.
- **Write value:**
  - BYTE: replicate `[7:0]` ×4.
  - HALF: replicate `[15:0]` ×2.
  - WORD: pass through.
- **Load extract:**
  - Shift the read word right by `8*addr[1:0]`.
  - Take 8 or 16 bits (or all 32).
  - Sign-extend unless `zero_extend`.
- **Reset:**
  - State is IDLE, `drop` = 0, all registers are 0.
  - Outputs: `bus_valid_out` 0, `mem_stall_req_out` 0, `read_value_out` 0, mask 0, address 0.
  - Reset during REQ abandons the transaction. The bus side must tolerate this.

## Timing
- Zero-wait bus (ready in the first REQ cycle): stall request is high for 2 cycles (IDLE issue, REQ). DONE is the third cycle, with the stage advancing.
- Each wait cycle with `bus_ready_in` = 0 adds one stall cycle.
- `bus_valid_out` is registered: no combinational path from the memory-stage inputs to the bus.
- `mem_stall_req_out` is combinational from the inputs and the state.
- Back-to-back accesses: minimum one request every 3 cycles.
- Simultaneous `bus_ready_in` and `flush_in` in REQ: the result is dropped, next state is IDLE.

## Structure
- Package `rv32_mem_pkg`:
  - `rv32_mem_width_t` enum.
  - State enum `rv32_lsu_state_t`.
- Sub-module `rv32_lsu_align`, purely combinational:
  - Mask and write-value generation.
  - Load extract/extend.
  - Misalignment check.

## Test plan
1. **Zero-wait word load:** LW at `0x1004`, bus ready immediately with `0xDEADBEEF`.
   - Stall high for 2 cycles, mask `0000`.
   - `read_value_out = 0xDEADBEEF` in DONE.
2. **Byte store:** SB `0xA5` to `0x2003`.
   - `bus_address_out = 0x2000`, mask `1000`, value `0xA5A5A5A5`, write = 1.
3. **Half load with waits:** LH at `0x0102`, ready after 3 wait cycles, read word `0x80FF1234`.
   - Stall for 5 cycles.
   - `read_value_out = 0xFFFF80FF`.
   - Same access with LHU gives `0x000080FF`.
4. **Misaligned:** LW at `0x0001`.
   - `misaligned_out = 1`, `bus_valid_out` never asserted, stall stays 0.
5. **Flush in REQ:** flush one cycle after issue, ready two cycles later.
   - Request fields stay stable until ready.
   - No DONE, no result.
   - A new SW waiting behind it sees its stall held until the bus frees, then issues.
6. **Reset mid-REQ:** `reset_n` low during REQ.
   - All outputs 0 immediately, state IDLE, `drop` = 0.

Source files
------------

// File: rtl/rv32_mem_pkg.sv
// Shared types for the RV32 memory-stage load/store unit.
//   rv32_mem_width_t  : access size of a load/store (byte, half, word)
//   rv32_lsu_state_t  : LSU transaction state (idle, bus request, result done)
package rv32_mem_pkg;

  typedef enum logic [1:0] {
    MemByte = 2'd0,
    MemHalf = 2'd1,
    MemWord = 2'd2
  } rv32_mem_width_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StDone = 2'd2
  } rv32_lsu_state_t;

endpackage

// File: rtl/rv32_lsu_align.sv
// Byte-lane alignment for the load/store unit. Purely combinational.
// Store side works on the access currently in the memory stage; load side works on the
// registered access whose bus word is being returned.
//   i_width, i_addr_lo, i_write, i_wdata : store-side access description
//   o_mask, o_wvalue                     : byte enables and lane-replicated store data
//   o_misaligned                         : access crosses its natural alignment
//   i_ld_width, i_ld_off, i_ld_zext      : registered load description
//   i_ld_word                            : raw 32-bit bus read word
//   o_ld_value                           : extracted and extended load result
module rv32_lsu_align
  import rv32_mem_pkg::*;
(
  input  rv32_mem_width_t i_width,
  input  logic [1:0]      i_addr_lo,
  input  logic            i_write,
  input  logic [31:0]     i_wdata,
  output logic [3:0]      o_mask,
  output logic [31:0]     o_wvalue,
  output logic            o_misaligned,
  input  rv32_mem_width_t i_ld_width,
  input  logic [1:0]      i_ld_off,
  input  logic            i_ld_zext,
  input  logic [31:0]     i_ld_word,
  output logic [31:0]     o_ld_value
);

  logic [31:0] w_shifted;

  always_comb begin
    o_mask       = 4'b0000;
    o_wvalue     = i_wdata;
    o_misaligned = 1'b0;
    case (i_width)
      MemByte: begin
        o_mask   = 4'b0001 << i_addr_lo;
        o_wvalue = {4{i_wdata[7:0]}};
      end
      MemHalf: begin
        o_mask       = 4'b0011 << i_addr_lo;
        o_wvalue     = {2{i_wdata[15:0]}};
        o_misaligned = i_addr_lo[0];
      end
      default: begin
        o_mask       = 4'b1111;
        o_misaligned = (i_addr_lo != 2'b00);
      end
    endcase
    // Loads never enable byte writes.
    if (!i_write) begin
      o_mask = 4'b0000;
    end
  end

  always_comb begin
    w_shifted = i_ld_word >> {i_ld_off, 3'b000};
    case (i_ld_width)
      MemByte: o_ld_value = {{24{~i_ld_zext & w_shifted[7]}}, w_shifted[7:0]};
      MemHalf: o_ld_value = {{16{~i_ld_zext & w_shifted[15]}}, w_shifted[15:0]};
      default: o_ld_value = w_shifted;
    endcase
  end

endmodule

// File: rtl/rv32_lsu.sv
// RV32 memory-stage load/store unit. Turns one load/store into a single valid/ready bus
// transaction, aligns byte lanes, extends load data and requests a pipeline stall until
// the access completes.
//   clk, reset_n                       : clock, asynchronous active-low reset
//   read_en_in, write_en_in            : load / store present in the stage
//   width_in, zero_extend_in           : access size, unsigned load
//   address_in, write_value_in         : effective address, store data (low bits)
//   stall_in, flush_in                 : hold / squash from the hazard unit
//   read_value_out                     : extended load result, valid in DONE
//   mem_stall_req_out                  : access not yet complete
//   misaligned_out                     : access is misaligned, bus untouched
//   bus_*                              : word-addressed valid/ready data bus
module rv32_lsu
  import rv32_mem_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            read_en_in,
  input  logic            write_en_in,
  input  rv32_mem_width_t width_in,
  input  logic            zero_extend_in,
  input  logic [31:0]     address_in,
  input  logic [31:0]     write_value_in,
  input  logic            stall_in,
  input  logic            flush_in,
  output logic [31:0]     read_value_out,
  output logic            mem_stall_req_out,
  output logic            misaligned_out,
  output logic [31:0]     bus_address_out,
  output logic            bus_valid_out,
  output logic            bus_write_out,
  output logic [3:0]      bus_write_mask_out,
  output logic [31:0]     bus_write_value_out,
  input  logic            bus_ready_in,
  input  logic [31:0]     bus_read_value_in
);

  rv32_lsu_state_t r_state, w_state_next;
  logic            r_drop, w_drop_next;
  logic [31:0]     r_addr;
  logic [3:0]      r_mask;
  logic [31:0]     r_wdata;
  logic            r_write;
  rv32_mem_width_t r_width;
  logic            r_zext;
  logic [1:0]      r_off;
  logic [31:0]     r_read_value;

  logic            w_access;
  logic            w_issue;
  logic            w_capture;
  logic [3:0]      w_mask;
  logic [31:0]     w_wvalue;
  logic            w_misaligned;
  logic [31:0]     w_ld_value;

  rv32_lsu_align u_align (
    .i_width      (width_in),
    .i_addr_lo    (address_in[1:0]),
    .i_write      (write_en_in),
    .i_wdata      (write_value_in),
    .o_mask       (w_mask),
    .o_wvalue     (w_wvalue),
    .o_misaligned (w_misaligned),
    .i_ld_width   (r_width),
    .i_ld_off     (r_off),
    .i_ld_zext    (r_zext),
    .i_ld_word    (bus_read_value_in),
    .o_ld_value   (w_ld_value)
  );

  // Only flag misalignment when there is actually an access in the stage.
  assign misaligned_out = (read_en_in | write_en_in) & w_misaligned;
  assign w_access       = (read_en_in | write_en_in) & ~flush_in & ~misaligned_out;

  // While a dropped transaction is still on the bus, this holds a new access back too.
  assign mem_stall_req_out = w_access & ((r_state == StIdle) | (r_state == StReq));

  always_comb begin
    w_state_next = r_state;
    w_drop_next  = r_drop;
    w_issue      = 1'b0;
    w_capture    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_access) begin
          w_issue      = 1'b1;
          w_state_next = StReq;
        end
      end
      StReq: begin
        // The bus transaction is never aborted; a flush only discards its result.
        if (bus_ready_in) begin
          w_drop_next = 1'b0;
          if (r_drop || flush_in) begin
            w_state_next = StIdle;
          end else begin
            w_capture    = 1'b1;
            w_state_next = StDone;
          end
        end else if (flush_in) begin
          w_drop_next = 1'b1;
        end
      end
      StDone: begin
        if (!stall_in || flush_in) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_drop  <= w_drop_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr       <= '0;
      r_mask       <= '0;
      r_wdata      <= '0;
      r_write      <= 1'b0;
      r_width      <= MemByte;
      r_zext       <= 1'b0;
      r_off        <= '0;
      r_read_value <= '0;
    end else begin
      if (w_issue) begin
        r_addr  <= {address_in[31:2], 2'b00};
        r_mask  <= w_mask;
        r_wdata <= w_wvalue;
        r_write <= write_en_in;
        r_width <= width_in;
        r_zext  <= zero_extend_in;
        r_off   <= address_in[1:0];
      end
      if (w_capture) begin
        r_read_value <= w_ld_value;
      end
    end
  end

  assign bus_valid_out       = (r_state == StReq);
  assign bus_address_out     = r_addr;
  assign bus_write_out       = r_write;
  assign bus_write_mask_out  = r_mask;
  assign bus_write_value_out = r_wdata;
  assign read_value_out      = r_read_value;

endmodule

// File: tb/tb_rv32_lsu.sv
module tb_rv32_lsu;
  import rv32_mem_pkg::*;

  logic            clk;
  logic            reset_n;
  logic            read_en_in;
  logic            write_en_in;
  rv32_mem_width_t width_in;
  logic            zero_extend_in;
  logic [31:0]     address_in;
  logic [31:0]     write_value_in;
  logic            stall_in;
  logic            flush_in;
  logic [31:0]     read_value_out;
  logic            mem_stall_req_out;
  logic            misaligned_out;
  logic [31:0]     bus_address_out;
  logic            bus_valid_out;
  logic            bus_write_out;
  logic [3:0]      bus_write_mask_out;
  logic [31:0]     bus_write_value_out;
  logic            bus_ready_in;
  logic [31:0]     bus_read_value_in;

  rv32_lsu dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .read_en_in          (read_en_in),
    .write_en_in         (write_en_in),
    .width_in            (width_in),
    .zero_extend_in      (zero_extend_in),
    .address_in          (address_in),
    .write_value_in      (write_value_in),
    .stall_in            (stall_in),
    .flush_in            (flush_in),
    .read_value_out      (read_value_out),
    .mem_stall_req_out   (mem_stall_req_out),
    .misaligned_out      (misaligned_out),
    .bus_address_out     (bus_address_out),
    .bus_valid_out       (bus_valid_out),
    .bus_write_out       (bus_write_out),
    .bus_write_mask_out  (bus_write_mask_out),
    .bus_write_value_out (bus_write_value_out),
    .bus_ready_in        (bus_ready_in),
    .bus_read_value_in   (bus_read_value_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wval;
    logic        wr;
  } bus_exp_t;

  bus_exp_t    bus_q[$];
  logic [31:0] rd_q[$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    read_en_in     = 1'b0;
    write_en_in    = 1'b0;
    width_in       = MemWord;
    zero_extend_in = 1'b0;
    address_in     = '0;
    write_value_in = '0;
    stall_in       = 1'b0;
    flush_in       = 1'b0;
  endtask

  // Entered just after a rising edge with the DUT in IDLE; returns just after the edge
  // that leaves DONE, with the stage inputs cleared.
  task automatic do_access(input string name, input logic rd, input logic wr,
                           input rv32_mem_width_t w, input logic zx,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int waits, input logic [31:0] rword,
                           input logic [31:0] exp_rd, input logic [3:0] exp_mask,
                           input logic [31:0] exp_wval);
    bus_exp_t cur;
    bus_exp_t e;
    bit       have = 0;
    bit       done = 0;
    bit       ready_prev = 0;
    bit       ready_now;
    int       stalls = 0;
    int       wcnt = 0;
    e.addr = {addr[31:2], 2'b00};
    e.mask = exp_mask;
    e.wval = exp_wval;
    e.wr   = wr;
    bus_q.push_back(e);
    if (rd) rd_q.push_back(exp_rd);
    read_en_in     = rd;
    write_en_in    = wr;
    width_in       = w;
    zero_extend_in = zx;
    address_in     = addr;
    write_value_in = wdata;
    bus_ready_in   = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      ready_now = 0;
      #1;
      if (bus_valid_out) begin
        if (!have) begin
          chk({name, "_bus_q_nonempty"}, 32'(bus_q.size() != 0), 32'd1);
          if (bus_q.size() != 0) cur = bus_q.pop_front();
          have = 1;
        end
        chk({name, "_bus_addr"}, bus_address_out, cur.addr);
        chk({name, "_bus_mask"}, 32'(bus_write_mask_out), 32'(cur.mask));
        chk({name, "_bus_wval"}, bus_write_value_out, cur.wval);
        chk({name, "_bus_write"}, 32'(bus_write_out), 32'(cur.wr));
        ready_now         = (wcnt == waits);
        bus_ready_in      = ready_now;
        bus_read_value_in = rword;
        if (wcnt < waits) wcnt++;
      end
      #1;
      if (mem_stall_req_out) stalls++;
      if (!ready_prev) begin
        chk({name, "_stall_held"}, 32'(mem_stall_req_out), 32'd1);
      end else begin
        done = 1;
        chk({name, "_done_stall"}, 32'(mem_stall_req_out), 32'd0);
        chk({name, "_done_valid"}, 32'(bus_valid_out), 32'd0);
        chk({name, "_stall_cycles"}, 32'(stalls), 32'(2 + waits));
        if (rd) begin
          chk({name, "_rd_q_nonempty"}, 32'(rd_q.size() != 0), 32'd1);
          if (rd_q.size() != 0) chk({name, "_read_value"}, read_value_out, rd_q.pop_front());
        end
      end
      chk({name, "_misaligned"}, 32'(misaligned_out), 32'd0);
      ready_prev = ready_now;
      @(posedge clk);
      #1;
      bus_ready_in = 1'b0;
    end
    chk({name, "_completed"}, 32'(done), 32'd1);
    idle_inputs();
  endtask

  initial begin
    reset_n           = 1'b0;
    bus_ready_in      = 1'b0;
    bus_read_value_in = '0;
    idle_inputs();
    #3;
    chk("reset_valid", 32'(bus_valid_out), 32'd0);
    chk("reset_stall", 32'(mem_stall_req_out), 32'd0);
    chk("reset_read_value", read_value_out, 32'd0);
    chk("reset_mask", 32'(bus_write_mask_out), 32'd0);
    chk("reset_addr", bus_address_out, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    //         name    rd wr width    zx addr          wdata         w  rword
    do_access("lw",    1, 0, MemWord, 0, 32'h0000_1004, 32'h0,        0, 32'hDEAD_BEEF,
              32'hDEAD_BEEF, 4'b0000, 32'h0);
    do_access("sb",    0, 1, MemByte, 0, 32'h0000_2003, 32'h1234_56A5, 0, 32'h0,
              32'h0, 4'b1000, 32'hA5A5_A5A5);
    do_access("lh",    1, 0, MemHalf, 0, 32'h0000_0102, 32'h0,        3, 32'h80FF_1234,
              32'hFFFF_80FF, 4'b0000, 32'h0);
    do_access("lhu",   1, 0, MemHalf, 1, 32'h0000_0102, 32'h0,        3, 32'h80FF_1234,
              32'h0000_80FF, 4'b0000, 32'h0);
    do_access("sh",    0, 1, MemHalf, 0, 32'h0000_2002, 32'hBEEF_1234, 0, 32'h0,
              32'h0, 4'b1100, 32'h1234_1234);
    do_access("lb",    1, 0, MemByte, 0, 32'h0000_3001, 32'h0,        0, 32'h1122_8344,
              32'hFFFF_FF83, 4'b0000, 32'h0);
    do_access("lbu",   1, 0, MemByte, 1, 32'h0000_3001, 32'h0,        1, 32'h1122_8344,
              32'h0000_0083, 4'b0000, 32'h0);
    do_access("sw",    0, 1, MemWord, 0, 32'h0000_4000, 32'hCAFE_F00D, 2, 32'h0,
              32'h0, 4'b1111, 32'hCAFE_F00D);

    // Misaligned word load and half store: no request, no stall.
    read_en_in = 1'b1;
    width_in   = MemWord;
    address_in = 32'h0000_0001;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mis_lw_flag", 32'(misaligned_out), 32'd1);
      chk("mis_lw_valid", 32'(bus_valid_out), 32'd0);
      chk("mis_lw_stall", 32'(mem_stall_req_out), 32'd0);
      @(posedge clk);
      #1;
    end
    read_en_in  = 1'b0;
    write_en_in = 1'b1;
    width_in    = MemHalf;
    address_in  = 32'h0000_0003;
    #1;
    chk("mis_sh_flag", 32'(misaligned_out), 32'd1);
    chk("mis_sh_stall", 32'(mem_stall_req_out), 32'd0);
    @(posedge clk);
    #1;
    chk("mis_sh_valid", 32'(bus_valid_out), 32'd0);
    idle_inputs();

    // Flush one cycle after issue; a SW queued behind the dropped load.
    read_en_in = 1'b1;
    width_in   = MemWord;
    address_in = 32'h0000_5000;
    #1;
    chk("fl_issue_stall", 32'(mem_stall_req_out), 32'd1);
    @(posedge clk);
    #1;
    flush_in = 1'b1;
    #1;
    chk("fl_req_valid", 32'(bus_valid_out), 32'd1);
    chk("fl_req_addr", bus_address_out, 32'h0000_5000);
    chk("fl_flush_stall", 32'(mem_stall_req_out), 32'd0);
    @(posedge clk);
    #1;
    flush_in       = 1'b0;
    read_en_in     = 1'b0;
    write_en_in    = 1'b1;
    address_in     = 32'h0000_6008;
    write_value_in = 32'h0BAD_F00D;
    #1;
    chk("fl_hold_valid", 32'(bus_valid_out), 32'd1);
    chk("fl_hold_addr", bus_address_out, 32'h0000_5000);
    chk("fl_hold_write", 32'(bus_write_out), 32'd0);
    chk("fl_hold_mask", 32'(bus_write_mask_out), 32'd0);
    chk("fl_sw_stall_busy", 32'(mem_stall_req_out), 32'd1);
    @(posedge clk);
    #1;
    bus_ready_in      = 1'b1;
    bus_read_value_in = 32'h5555_5555;
    #1;
    chk("fl_ready_addr", bus_address_out, 32'h0000_5000);
    chk("fl_ready_stall", 32'(mem_stall_req_out), 32'd1);
    @(posedge clk);
    #1;
    bus_ready_in = 1'b0;
    #1;
    chk("fl_no_done_valid", 32'(bus_valid_out), 32'd0);
    chk("fl_no_done_stall", 32'(mem_stall_req_out), 32'd1);
    @(posedge clk);
    #1;
    bus_ready_in = 1'b1;
    #1;
    chk("fl_sw_valid", 32'(bus_valid_out), 32'd1);
    chk("fl_sw_addr", bus_address_out, 32'h0000_6008);
    chk("fl_sw_mask", 32'(bus_write_mask_out), 32'hF);
    chk("fl_sw_wval", bus_write_value_out, 32'h0BAD_F00D);
    chk("fl_sw_write", 32'(bus_write_out), 32'd1);
    @(posedge clk);
    #1;
    bus_ready_in = 1'b0;
    #1;
    chk("fl_sw_done_stall", 32'(mem_stall_req_out), 32'd0);
    @(posedge clk);
    #1;
    idle_inputs();

    // Reset while a store is on the bus.
    write_en_in    = 1'b1;
    width_in       = MemWord;
    address_in     = 32'h0000_7000;
    write_value_in = 32'h1234_5678;
    @(posedge clk);
    #1;
    chk("rst_pre_valid", 32'(bus_valid_out), 32'd1);
    chk("rst_pre_mask", 32'(bus_write_mask_out), 32'hF);
    reset_n     = 1'b0;
    write_en_in = 1'b0;
    #1;
    chk("rst_valid", 32'(bus_valid_out), 32'd0);
    chk("rst_stall", 32'(mem_stall_req_out), 32'd0);
    chk("rst_read_value", read_value_out, 32'd0);
    chk("rst_mask", 32'(bus_write_mask_out), 32'd0);
    chk("rst_addr", bus_address_out, 32'd0);
    chk("rst_write", 32'(bus_write_out), 32'd0);
    chk("rst_wval", bus_write_value_out, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_after_valid", 32'(bus_valid_out), 32'd0);
    do_access("lbu_post_rst", 1, 0, MemByte, 1, 32'h0000_0003, 32'h0, 0, 32'hAB00_0000,
              32'h0000_00AB, 4'b0000, 32'h0);

    chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
    chk("rd_q_drained", 32'(rd_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
